// File: rtl/ram_block_copier.sv
// ram_block_copier: copies a block of RAM words from src to dst through RAM read port 1 and the write port
//
// Optional feature: define RAM_BLOCK_COPIER_FILL_EN to add block fill (fill, fill_value).
//
// Ports:
//   clock       rising-edge clock, shared with the RAM
//   reset_n     synchronous active-low reset
//   start       request pulse, accepted only when idle
//   src, dst    source / destination start addresses, captured on an accepted start
//   len         word count 0..2**AW (larger values clamp to 2**AW), captured on an accepted start
//   fill        (FILL_EN) write fill_value instead of copying, 1 cycle per word
//   fill_value  (FILL_EN) constant written in fill mode
//   busy        high from the cycle after an accepted start until the done cycle ends
//   done        one-cycle completion pulse
//   re1, raddr1 RAM read port 1 enable / address; rdata1 is its combinational data
//   we, waddr, wdata  RAM write port, committed by the RAM on the rising edge
module ram_block_copier #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
`ifdef RAM_BLOCK_COPIER_FILL_EN
    input  logic          fill,
    input  logic [DW-1:0] fill_value,
`endif
    output logic          busy,
    output logic          done,
    output logic          re1,
    output logic [AW-1:0] raddr1,
    input  logic [DW-1:0] rdata1,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} state_t;

    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    state_t        state;
    logic [AW-1:0] cur_src;
    logic [AW-1:0] cur_dst;
    logic [AW:0]   remaining;
    logic [AW:0]   len_c;
    logic          start_fill;
    logic [DW-1:0] fill_word;
    logic          fill_q;

    assign len_c = (len > FULL) ? FULL : len;

`ifdef RAM_BLOCK_COPIER_FILL_EN
    assign start_fill = fill;
    assign fill_word  = fill_value;
`else
    assign start_fill = 1'b0;
    assign fill_word  = '0;
    assign fill_q     = 1'b0;
`endif

    // All bus outputs are registered: each state's outputs are loaded on the edge that enters it.
    // wdata doubles as the hold register for the word read in READ, and keeps fill_value in fill mode.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            re1       <= 1'b0;
            we        <= 1'b0;
            raddr1    <= '0;
            waddr     <= '0;
            wdata     <= '0;
            cur_src   <= '0;
            cur_dst   <= '0;
            remaining <= '0;
`ifdef RAM_BLOCK_COPIER_FILL_EN
            fill_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_src   <= src;
                        cur_dst   <= dst;
                        remaining <= len_c;
                        busy      <= 1'b1;
`ifdef RAM_BLOCK_COPIER_FILL_EN
                        fill_q    <= fill;
`endif
                        if (len_c == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else if (start_fill) begin
                            state <= WRITE;
                            we    <= 1'b1;
                            waddr <= dst;
                            wdata <= fill_word;
                        end else begin
                            state  <= READ;
                            re1    <= 1'b1;
                            raddr1 <= src;
                        end
                    end
                end
                READ: begin
                    state <= WRITE;
                    re1   <= 1'b0;
                    we    <= 1'b1;
                    waddr <= cur_dst;
                    wdata <= rdata1;
                end
                WRITE: begin
                    cur_src   <= cur_src + AW'(1);
                    cur_dst   <= cur_dst + AW'(1);
                    remaining <= remaining - ONE;
                    if (remaining == ONE) begin
                        state <= FIN;
                        we    <= 1'b0;
                        done  <= 1'b1;
                    end else if (fill_q) begin
                        waddr <= cur_dst + AW'(1);
                    end else begin
                        state  <= READ;
                        we     <= 1'b0;
                        re1    <= 1'b1;
                        raddr1 <= cur_src + AW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_block_copier.sv
// tb_ram_block_copier: randomized and directed self-checking bench for ram_block_copier with a RAM model
module tb_ram_block_copier;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int D  = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [AW:0]   len = '0;
    logic          busy, done, re1, we;
    logic [AW-1:0] raddr1, waddr;
    logic [DW-1:0] rdata1, wdata;
`ifdef RAM_BLOCK_COPIER_FILL_EN
    logic          fill = 1'b0;
    logic [DW-1:0] fill_value = '0;
`endif

    logic [DW-1:0] mem [D];
    logic [DW-1:0] img [D];
    logic [DW-1:0] exp_mem [D];
    logic          load = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    assign rdata1 = mem[raddr1];

    always @(posedge clock) begin
        if (load) mem <= img;
        else if (we) mem[waddr] <= wdata;
    end

    ram_block_copier #(.AW(AW), .DW(DW)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .src(src),
        .dst(dst),
        .len(len),
`ifdef RAM_BLOCK_COPIER_FILL_EN
        .fill(fill),
        .fill_value(fill_value),
`endif
        .busy(busy),
        .done(done),
        .re1(re1),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .we(we),
        .waddr(waddr),
        .wdata(wdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic load_img();
        @(negedge clock);
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        for (int i = 0; i < D; i++) exp_mem[i] = img[i];
    endtask

    task automatic rand_img();
        for (int i = 0; i < D; i++) img[i] = DW'($urandom);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < D; i++) check($sformatf("%s_mem[%0d]", tag, i), 32'(mem[i]), 32'(exp_mem[i]));
    endtask

    // Issues one request and checks timing, bus activity, read order and final RAM contents.
    task automatic run(input string tag, input int s, input int d, input int l, input bit f, input logic [7:0] fv);
        int n, exp_cyc, done_at, busy_n, re_n, we_n, both;
        int rq[$];
        n = (l > D) ? D : l;
        exp_cyc = (f ? n : 2 * n) + 1;
        done_at = 0; busy_n = 0; re_n = 0; we_n = 0; both = 0;
        @(negedge clock);
        src = AW'(s); dst = AW'(d); len = (AW + 1)'(l); start = 1'b1;
`ifdef RAM_BLOCK_COPIER_FILL_EN
        fill = f; fill_value = fv;
`endif
        @(posedge clock);
        for (int cyc = 1; cyc <= 200 && done_at == 0; cyc++) begin
            @(negedge clock);
            // a second request while busy must be ignored
            start = (cyc == 1 && n >= 2);
            if (start) begin src = ~src; dst = ~dst; len = 6'd7; end
            busy_n += int'(busy);
            we_n   += int'(we);
            both   += int'(re1 & we);
            if (re1) begin re_n++; rq.push_back(int'(raddr1)); end
            if (done) done_at = cyc;
        end
        check({tag, "_done_latency"}, 32'(done_at), 32'(exp_cyc));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_cyc));
        @(negedge clock);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_re_count"}, 32'(re_n), 32'(f ? 0 : n));
        check({tag, "_we_count"}, 32'(we_n), 32'(n));
        check({tag, "_re_we_both"}, 32'(both), 32'd0);
        for (int i = 0; i < rq.size(); i++) check($sformatf("%s_raddr%0d", tag, i), 32'(rq[i]), 32'((s + i) % D));
        for (int i = 0; i < n; i++) exp_mem[(d + i) % D] = f ? fv : exp_mem[(s + i) % D];
        check_mem(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_re1", 32'(re1), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_raddr1", 32'(raddr1), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        reset_n = 1'b1;

        rand_img();
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        load_img();
        run("basic", 0, 8, 4, 1'b0, 8'h00);
        check("basic_w8", 32'(mem[8]), 32'h11);
        check("basic_w11", 32'(mem[11]), 32'h44);

        rand_img();
        img[30] = 8'hA1; img[31] = 8'hA2; img[0] = 8'hA3; img[1] = 8'hA4;
        load_img();
        run("wrap", 30, 2, 4, 1'b0, 8'h00);
        check("wrap_w5", 32'(mem[5]), 32'hA4);

        run("len0", 5, 9, 0, 1'b0, 8'h00);

        rand_img();
        img[0] = 8'd1; img[1] = 8'd2; img[2] = 8'd3; img[3] = 8'd4;
        load_img();
        run("overlap", 0, 1, 3, 1'b0, 8'h00);
        check("overlap_w3", 32'(mem[3]), 32'd1);

        run("same", 7, 7, 5, 1'b0, 8'h00);
        run("clamp", 3, 7, 40, 1'b0, 8'h00);

        // reset sampled on the edge that would begin the second write
        rand_img();
        load_img();
        @(negedge clock);
        src = 5'd4; dst = 5'd20; len = 6'd4; start = 1'b1;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        @(negedge clock); reset_n = 1'b0;
        @(negedge clock);
        check("rstmid_we", 32'(we), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_re1", 32'(re1), 32'd0);
        reset_n = 1'b1;
        exp_mem[20] = exp_mem[4];
        check_mem("rstmid");
        run("after_rst", 4, 20, 4, 1'b0, 8'h00);

        for (int k = 0; k < 6; k++) begin
            rand_img();
            load_img();
            run($sformatf("rand%0d", k), int'($urandom_range(0, D - 1)), int'($urandom_range(0, D - 1)),
                int'($urandom_range(0, 63)), 1'b0, 8'h00);
        end

`ifdef RAM_BLOCK_COPIER_FILL_EN
        rand_img();
        load_img();
        run("fill", 0, 16, 32, 1'b1, 8'hFF);
        run("fill_short", 0, 3, 5, 1'b1, 8'h5A);
        run("fill_off", 10, 2, 3, 1'b0, 8'h77);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
